conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_ctrl_pkg.sv | 33 +++
 rtl/dstream.sv | 11 +
 rtl/conv_frame_ctrl_coef_bank.sv | 48 ++++
 rtl/conv_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution frame controller.
// Optional abort support in conv_frame_ctrl is enabled with CONV_FRAME_CTRL_ABORT_EN.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int DEFAULT_GAP       = 2;
  localparam int DEFAULT_DRAIN_CYC = 2;

  // Address width for a bank of n_coef entries (never below one bit).
  function automatic int coef_addr_w(input int n_coef);
    if (n_coef > 1) begin
      return $clog2(n_coef);
    end else begin
      return 1;
    end
  endfunction

  // Width of a counter that runs 0 .. n-1.
  function automatic int cnt_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/dstream.sv
// Valid/ready data stream; "in" is the consumer side, "out" the producer side.
interface dstream #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport in  (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/conv_frame_ctrl_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, swap flips
// which bank drives kernel_flat.
module coef_bank
  import conv_ctrl_pkg::*;
#(
  parameter int W = 32,
  parameter int K = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [coef_addr_w(K*K)-1:0]    addr,
  input  logic [W-1:0]                   data,
  input  logic                           swap,
  output logic [K*K*W-1:0]               kernel_flat
);

  localparam int N = K * K;

  logic [N-1:0][W-1:0] bank0_r;
  logic [N-1:0][W-1:0] bank1_r;
  logic                bank_sel_r;
  logic                addr_ok_s;

  assign addr_ok_s   = (int'(addr) < N);
  assign kernel_flat = bank_sel_r ? bank1_r : bank0_r;

  // Shadow-bank writes and bank selection; the shadow is the bank not selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_r    <= '0;
      bank1_r    <= '0;
      bank_sel_r <= 1'b0;
    end else begin
      if (we && addr_ok_s) begin
        if (bank_sel_r) begin
          bank0_r[addr] <= data;
        end else begin
          bank1_r[addr] <= data;
        end
      end
      if (swap) begin
        bank_sel_r <= ~bank_sel_r;
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer feeding a convolution engine with a double-buffered kernel.
// Define CONV_FRAME_CTRL_ABORT_EN to add the abort input and aborted pulse.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int W         = 32,
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int K         = 5,
  parameter int GAP       = DEFAULT_GAP,
  parameter int DRAIN_CYC = DEFAULT_DRAIN_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dstream.in                          src,
  dstream.out                         eng,
  input  logic                        start,
  input  logic                        coef_we,
  input  logic [coef_addr_w(K*K)-1:0] coef_addr,
  input  logic [W-1:0]                coef_data,
  input  logic                        coef_commit,
`ifdef CONV_FRAME_CTRL_ABORT_EN
  input  logic                        abort,
  output logic                        aborted,
`endif
  output logic [K*K*W-1:0]            kernel_flat,
  output logic                        busy,
  output logic                        done,
  output logic                        swap_pend,
  output logic [15:0]                 frame_cnt
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = cnt_w(NPIX);
  localparam int GAP_W = cnt_w(GAP);
  localparam int DRN_W = cnt_w(DRAIN_CYC);

  state_t           state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [PIX_W-1:0] pix_cnt_r;
  logic [DRN_W-1:0] drain_cnt_r;
  logic [15:0]      frame_cnt_r;
  logic             done_r;
  logic             abort_flag_r;
  logic             swap_pend_r;
`ifdef CONV_FRAME_CTRL_ABORT_EN
  logic             aborted_r;
`endif

  logic st_stream_s;
  logic hs_s;
  logic abort_s;
  logic last_pix_s;
  logic drain_last_s;
  logic enter_drain_s;
  logic pulse_next_s;
  logic pulse_abort_s;
  logic swap_s;
  logic bank_we_s;

  // The stream path is a pure pass-through gated by the STREAM state.
  assign st_stream_s = (state_r == ST_STREAM);
  assign eng.data    = src.data;
  assign eng.valid   = st_stream_s & src.valid;
  assign src.ready   = st_stream_s & eng.ready;
  assign hs_s        = src.valid & src.ready;

`ifdef CONV_FRAME_CTRL_ABORT_EN
  assign abort_s = abort & ((state_r == ST_GAP) | (state_r == ST_STREAM));
  assign aborted = aborted_r;
`else
  assign abort_s = 1'b0;
`endif

  assign bank_we_s = coef_we & ~swap_pend_r;
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign swap_pend = swap_pend_r;
  assign frame_cnt = frame_cnt_r;

  // End-of-frame decode; the done/aborted pulse is registered one cycle ahead
  // so it lines up with the last DRAIN cycle.
  always_comb begin
    last_pix_s    = st_stream_s && hs_s && (pix_cnt_r == PIX_W'(NPIX - 1));
    drain_last_s  = (state_r == ST_DRAIN) && (drain_cnt_r == DRN_W'(DRAIN_CYC - 1));
    enter_drain_s = abort_s || last_pix_s;
    if (enter_drain_s) begin
      pulse_next_s  = (DRAIN_CYC == 1);
      pulse_abort_s = abort_s;
    end else if ((state_r == ST_DRAIN) && !drain_last_s) begin
      pulse_next_s  = (int'(drain_cnt_r) == DRAIN_CYC - 2);
      pulse_abort_s = abort_flag_r;
    end else begin
      pulse_next_s  = 1'b0;
      pulse_abort_s = 1'b0;
    end
    swap_s = ((state_r == ST_IDLE) && (coef_commit || swap_pend_r)) ||
             (drain_last_s && swap_pend_r);
  end

  // Frame FSM, counters, end-of-frame pulses and swap bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      gap_cnt_r    <= '0;
      pix_cnt_r    <= '0;
      drain_cnt_r  <= '0;
      frame_cnt_r  <= 16'd0;
      done_r       <= 1'b0;
      abort_flag_r <= 1'b0;
      swap_pend_r  <= 1'b0;
`ifdef CONV_FRAME_CTRL_ABORT_EN
      aborted_r    <= 1'b0;
`endif
    end else begin
      done_r <= pulse_next_s & ~pulse_abort_s;
`ifdef CONV_FRAME_CTRL_ABORT_EN
      aborted_r <= pulse_next_s & pulse_abort_s;
`endif
      if (swap_s) begin
        swap_pend_r <= 1'b0;
      end else if (coef_commit) begin
        swap_pend_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= '0;
          end
        end
        ST_GAP: begin
          if (abort_s) begin
            state_r      <= ST_DRAIN;
            drain_cnt_r  <= '0;
            abort_flag_r <= 1'b1;
          end else if (gap_cnt_r == GAP_W'(GAP - 1)) begin
            state_r <= ST_STREAM;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        ST_STREAM: begin
          if (enter_drain_s) begin
            state_r      <= ST_DRAIN;
            drain_cnt_r  <= '0;
            pix_cnt_r    <= '0;
            abort_flag_r <= abort_s;
          end else if (hs_s) begin
            pix_cnt_r <= pix_cnt_r + PIX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_last_s) begin
            if (!abort_flag_r) begin
              frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            abort_flag_r <= 1'b0;
            gap_cnt_r    <= '0;
            state_r      <= start ? ST_GAP : ST_IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRN_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  coef_bank #(
    .W (W),
    .K (K)
  ) u_coef_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (bank_we_s),
    .addr        (coef_addr),
    .data        (coef_data),
    .swap        (swap_s),
    .kernel_flat (kernel_flat)
  );

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomised bench for conv_frame_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_conv_frame_ctrl;
  import conv_ctrl_pkg::*;

  localparam int W         = 32;
  localparam int WIDTH     = 8;
  localparam int HEIGHT    = 4;
  localparam int K         = 3;
  localparam int GAP       = 2;
  localparam int DRAIN_CYC = 2;
  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int NC        = K * K;
  localparam int AW        = coef_addr_w(NC);
  localparam int LIMIT     = 400;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [W-1:0]    coef_data;
  logic            coef_commit;
  logic [NC*W-1:0] kernel_flat;
  logic            busy;
  logic            done;
  logic            swap_pend;
  logic [15:0]     frame_cnt;
  logic            aborted_obs;
`ifdef CONV_FRAME_CTRL_ABORT_EN
  logic            abort_drv;
`endif

  dstream #(.W(W)) src_if ();
  dstream #(.W(W)) eng_if ();

  int errors = 0;
  int checks = 0;

  // Reference model: completed frames, two coefficient arrays, pending flag.
  int           m_frames;
  logic [W-1:0] m_active [NC];
  logic [W-1:0] m_shadow [NC];
  bit           m_pend;

  always #5 clk = ~clk;

  conv_frame_ctrl #(
    .W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .K(K), .GAP(GAP), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src         (src_if),
    .eng         (eng_if),
    .start       (start),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
`ifdef CONV_FRAME_CTRL_ABORT_EN
    .abort       (abort_drv),
    .aborted     (aborted_obs),
`endif
    .kernel_flat (kernel_flat),
    .busy        (busy),
    .done        (done),
    .swap_pend   (swap_pend),
    .frame_cnt   (frame_cnt)
  );

`ifndef CONV_FRAME_CTRL_ABORT_EN
  assign aborted_obs = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int kernel_bad();
    int bad = 0;
    for (int i = 0; i < NC; i++) begin
      if (kernel_flat[i*W +: W] !== m_active[i]) bad++;
    end
    return bad;
  endfunction

  task automatic model_swap();
    logic [W-1:0] tmp;
    for (int i = 0; i < NC; i++) begin
      tmp         = m_active[i];
      m_active[i] = m_shadow[i];
      m_shadow[i] = tmp;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_reset();
    m_frames = 0;
    m_pend   = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
  endtask

  // All tasks start and end just after a rising edge.
  task automatic write_coef(input int addr, input logic [W-1:0] data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (!m_pend && addr < NC) m_shadow[addr] = data;
  endtask

  task automatic commit_idle();
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
    model_swap();
    @(negedge clk);
    check_val("idle_swap_kernel", kernel_bad(), 0);
    check_val("idle_swap_pend", swap_pend, 1'b0);
    @(posedge clk); #1;
  endtask

  // rmode: 0 ready=1, 1 toggling, 2 random; vmode: 0 valid=1, 1 random.
  task automatic run_frame(input int rmode, input int vmode, input int commit_px,
                           input int rst_px, input int abort_px);
    int cyc = 0, hs = 0, end_cyc = -1, done_cyc = -1, abt_cyc = -1;
    int n_done = 0, n_abt = 0, vhi = 0;
    int bad_gap = 0, bad_stream = 0, bad_drain = 0, bad_kern = 0;
    bit commit_done = 1'b0, we_next = 1'b0, pend_seen = 1'b0, exp_abort = 1'b0;
    bit v_drv, r_drv, cm, ab, in_stream;
    logic [W-1:0] d_drv;
    while (1) begin
      start = (cyc == 0);
      v_drv = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r_drv = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      d_drv = $urandom;
      in_stream = (end_cyc < 0) && (cyc > GAP);
      cm = in_stream && commit_px >= 0 && !commit_done && hs == commit_px;
      ab = in_stream && abort_px >= 0 && hs == abort_px;
      coef_we     = we_next;
      coef_addr   = '0;
      coef_data   = 32'hDEAD_BEEF;
      coef_commit = cm;
      if (we_next && !m_pend) m_shadow[0] = 32'hDEAD_BEEF;
      we_next = cm;
      if (cm) begin
        commit_done = 1'b1;
        m_pend      = 1'b1;
      end
      src_if.valid = v_drv;
      src_if.data  = d_drv;
      eng_if.ready = r_drv;
`ifdef CONV_FRAME_CTRL_ABORT_EN
      abort_drv = ab;
`endif
      @(negedge clk);
      if (end_cyc < 0) begin
        if (cyc <= GAP) begin
          if (eng_if.valid !== 1'b0 || src_if.ready !== 1'b0) bad_gap++;
        end else begin
          if (src_if.ready !== r_drv || eng_if.valid !== v_drv ||
              (v_drv && eng_if.data !== d_drv)) bad_stream++;
          if (eng_if.valid === 1'b1) vhi++;
          if (v_drv && src_if.ready === 1'b1) hs++;
          if (ab) begin
            end_cyc   = cyc;
            exp_abort = 1'b1;
          end else if (hs == NPIX) begin
            end_cyc = cyc;
          end
        end
      end else if (cyc <= end_cyc + DRAIN_CYC) begin
        if (eng_if.valid !== 1'b0 || src_if.ready !== 1'b0) bad_drain++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (aborted_obs === 1'b1) begin
        n_abt++;
        if (abt_cyc < 0) abt_cyc = cyc;
      end
      if (end_cyc < 0 || cyc <= end_cyc + DRAIN_CYC) bad_kern += kernel_bad();
      if (commit_done && swap_pend === 1'b1) pend_seen = 1'b1;
      if (rst_px >= 0 && hs == rst_px) begin
        check_val("pend_before_reset", pend_seen, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_eng_valid", eng_if.valid, 1'b0);
        check_val("rst_src_ready", src_if.ready, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_swap_pend", swap_pend, 1'b0);
        check_val("rst_frame_cnt", frame_cnt, 16'd0);
        check_val("rst_kernel", kernel_bad(), 0);
        @(posedge clk); #1;
        start = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; src_if.valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (end_cyc >= 0 && cyc == end_cyc + DRAIN_CYC + 1) break;
      if (cyc >= LIMIT) begin
        check_val("frame_timeout", cyc, 0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    coef_we = 1'b0; coef_commit = 1'b0; start = 1'b0; src_if.valid = 1'b0;
    if (!exp_abort) m_frames++;
    if (m_pend) model_swap();
    check_val("gap_quiet", bad_gap, 0);
    check_val("stream_mirror", bad_stream, 0);
    check_val("drain_quiet", bad_drain, 0);
    check_val("kernel_stable", bad_kern, 0);
    if (exp_abort) begin
      check_val("abort_no_done", n_done, 0);
      check_val("aborted_pulses", n_abt, 1);
      check_val("aborted_cycle", abt_cyc, end_cyc + DRAIN_CYC);
    end else begin
      check_val("pixel_count", hs, NPIX);
      check_val("done_pulses", n_done, 1);
      check_val("done_cycle", done_cyc, end_cyc + DRAIN_CYC);
      check_val("aborted_none", n_abt, 0);
    end
    if (rmode == 0 && vmode == 0 && !exp_abort) check_val("valid_high_cycles", vhi, NPIX);
    if (commit_px >= 0) check_val("pend_seen", pend_seen, 1'b1);
    check_val("frame_cnt", frame_cnt, 16'(m_frames));
    check_val("busy_after", busy, 1'b0);
    check_val("swap_pend_after", swap_pend, 1'b0);
    check_val("kernel_after", kernel_bad(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    coef_commit = 1'b0; src_if.valid = 1'b0; src_if.data = '0; eng_if.ready = 1'b0;
`ifdef CONV_FRAME_CTRL_ABORT_EN
    abort_drv = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_done", done, 1'b0);
    check_val("reset_swap_pend", swap_pend, 1'b0);
    check_val("reset_frame_cnt", frame_cnt, 16'd0);
    check_val("reset_eng_valid", eng_if.valid, 1'b0);
    check_val("reset_src_ready", src_if.ready, 1'b0);
    check_val("reset_kernel", kernel_bad(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    write_coef(4, 32'h0001_0000);
    commit_idle();
    check_val("kernel_entry4", kernel_flat[4*W +: W], 32'h0001_0000);

    for (int i = 0; i < NC; i++) write_coef(i, $urandom);
    write_coef(12, 32'hBAD0_0BAD);
    commit_idle();

    run_frame(0, 0, -1, -1, -1);
    run_frame(1, 0, -1, -1, -1);
    write_coef(0, 32'h1234_5678);
    write_coef(5, $urandom);
    run_frame(2, 1, 10, -1, -1);
    run_frame(2, 1, -1, -1, -1);
    write_coef(2, $urandom);
    run_frame(0, 0, 10, 20, -1);
    run_frame(0, 0, -1, -1, -1);
`ifdef CONV_FRAME_CTRL_ABORT_EN
    write_coef(7, $urandom);
    run_frame(0, 0, 3, -1, 5);
    run_frame(0, 0, -1, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
